// File: rtl/dp_fpu_pkg.sv
// dp_fpu_pkg: shared widths, IEEE-754 constants and tag-width helper for the DP adder arbiter
package dp_fpu_pkg;
  localparam int FP_W = 64;
  localparam logic [FP_W-1:0] FP_QNAN = 64'h7FF8000000000000;
  localparam logic [FP_W-1:0] FP_PINF = 64'h7FF0000000000000;
  function automatic int req_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dp_adder.sv
// dp_adder: combinational IEEE-754 double add/subtract (op=1 subtracts b), round-to-nearest-even
module dp_adder
  import dp_fpu_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  input  logic            op,
  output logic [FP_W-1:0] result
);
  logic sb, swap, sx, sy, eff_sub, nan_a, nan_b, inf_a, inf_b, rnd;
  logic [62:0] mag_x, mag_y;
  logic [10:0] ex, ey, d;
  logic [55:0] mx, my, ys, m;
  logic [111:0] t;
  logic [56:0] n;
  logic [5:0] lz;
  logic [11:0] sh, e, eo;
  logic [53:0] mr;
  function automatic logic [5:0] clz(input logic [55:0] v);
    clz = 6'd56;
    for (int i = 0; i < 56; i++) if (v[i]) clz = 6'(55 - i);
  endfunction
  // align the smaller operand with G/R/S bits, add, normalise, round, then patch in specials
  always_comb begin
    sb = b[63] ^ op;
    nan_a = (&a[62:52]) & (|a[51:0]);
    nan_b = (&b[62:52]) & (|b[51:0]);
    inf_a = (&a[62:52]) & ~(|a[51:0]);
    inf_b = (&b[62:52]) & ~(|b[51:0]);
    swap = b[62:0] > a[62:0];
    sx = swap ? sb : a[63];
    sy = swap ? a[63] : sb;
    mag_x = swap ? b[62:0] : a[62:0];
    mag_y = swap ? a[62:0] : b[62:0];
    ex = (mag_x[62:52] == 11'd0) ? 11'd1 : mag_x[62:52];
    ey = (mag_y[62:52] == 11'd0) ? 11'd1 : mag_y[62:52];
    mx = {|mag_x[62:52], mag_x[51:0], 3'b000};
    my = {|mag_y[62:52], mag_y[51:0], 3'b000};
    d = ex - ey;
    t = {my, 56'b0} >> ((d > 11'd56) ? 7'd56 : d[6:0]);
    ys = {t[111:57], t[56] | (|t[55:0])};
    eff_sub = sx ^ sy;
    n = eff_sub ? {1'b0, mx} - {1'b0, ys} : {1'b0, mx} + {1'b0, ys};
    lz = clz(n[55:0]);
    sh = ({6'b0, lz} < {1'b0, ex}) ? {6'b0, lz} : {1'b0, ex} - 12'd1;
    m = n[56] ? {n[56:2], n[1] | n[0]} : n[55:0] << sh;
    e = n[56] ? {1'b0, ex} + 12'd1 : {1'b0, ex} - sh;
    rnd = m[2] & (m[1] | m[0] | m[3]);
    mr = {1'b0, m[55:3]} + {53'b0, rnd};
    eo = mr[53] ? e + 12'd1 : (mr[52] ? e : 12'd0);
    result = (nan_a | nan_b | (inf_a & inf_b & (a[63] != sb))) ? FP_QNAN
           : inf_a ? a
           : inf_b ? {sb, b[62:0]}
           : (eo >= 12'h7FF) ? (FP_PINF | {sx, 63'b0})
           : (mr == 54'd0) ? {sx & sy, 63'b0}
           : {sx, eo[10:0], mr[53] ? mr[52:1] : mr[51:0]};
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant searching upward from the last accepted requester
module rr_arbiter
  import dp_fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = req_id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  logic [ID_W-1:0] ptr;
  logic [ID_W:0] s;
  // scan farthest-first so the nearest valid requester after ptr wins
  always_comb begin
    idx = '0;
    any = 1'b0;
    s = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      s = {1'b0, ptr} + (ID_W+1)'(k);
      if (s >= (ID_W+1)'(NUM_REQ)) s = s - (ID_W+1)'(NUM_REQ);
      if (en && req[s[ID_W-1:0]]) begin
        any = 1'b1;
        idx = s[ID_W-1:0];
      end
    end
    gnt = any ? NUM_REQ'(1) << idx : '0;
  end
  // pointer follows each accept; reset value makes requester 0 first in line
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= ID_W'(NUM_REQ - 1);
    else if (any) ptr <= idx;
endmodule

// File: rtl/dp_add_arbiter.sv
// dp_add_arbiter: shares one dp_adder among NUM_REQ requesters via round-robin and a 2-stage pipeline
module dp_add_arbiter
  import dp_fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = req_id_w(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_op,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [FP_W-1:0]         resp_result,
  output logic                    busy
);
  logic s1_valid, s2_valid, s1_op, s1_en, s2_en, any;
  logic [FP_W-1:0] s1_a, s1_b, sum;
  logic [ID_W-1:0] s1_id, idx;
  assign s2_en = ~s2_valid | resp_ready;
  assign s1_en = ~s1_valid | s2_en;
  assign resp_valid = s2_valid;
  assign busy = s1_valid | s2_valid;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk(clk), .rst(rst), .req(req_valid), .en(s1_en & ~rst),
    .gnt(req_ready), .idx(idx), .any(any)
  );
  dp_adder u_add (.a(s1_a), .b(s1_b), .op(s1_op), .result(sum));
  // operand stage captures the granted slice; result stage registers the adder output
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_op <= 1'b0;
      s1_id <= '0;
      resp_id <= '0;
      resp_result <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= any;
        if (any) begin
          s1_a <= req_a[idx*FP_W +: FP_W];
          s1_b <= req_b[idx*FP_W +: FP_W];
          s1_op <= req_op[idx];
          s1_id <= idx;
        end
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        resp_result <= sum;
        resp_id <= s1_id;
      end
    end
endmodule

// File: tb/tb_dp_add_arbiter.sv
// tb_dp_add_arbiter: directed and random checks of the shared DP adder arbiter against a queue model
module tb_dp_add_arbiter;
  import dp_fpu_pkg::*;
  localparam int N = 4;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_op = '0;
  logic [N*64-1:0] req_a = '0;
  logic [N*64-1:0] req_b = '0;
  logic resp_ready = 1'b1;
  logic [N-1:0] req_ready;
  logic resp_valid, busy;
  logic [IW-1:0] resp_id;
  logic [63:0] resp_result;
  int checks = 0;
  int errors = 0;
  typedef struct {int id; logic [63:0] res;} exp_t;
  exp_t exp_q[$];
  int last = N - 1;
  bit acc_last = 1'b0;

  always #5 clk = ~clk;

  dp_add_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .busy(busy)
  );

  function automatic logic [63:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic op);
    logic [63:0] bb;
    bit na, nb, ia, ib;
    bb = {b[63] ^ op, b[62:0]};
    na = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
    nb = (bb[62:52] == 11'h7FF) && (bb[51:0] != 0);
    ia = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
    ib = (bb[62:52] == 11'h7FF) && (bb[51:0] == 0);
    if (na || nb || (ia && ib && a[63] != bb[63])) return FP_QNAN;
    return $realtobits($bitstoreal(a) + $bitstoreal(bb));
  endfunction

  function automatic logic [63:0] rand_fp();
    logic [63:0] f;
    f = {$urandom, $urandom};
    f[62:52] = 11'h3C0 + 11'($urandom_range(0, 127));
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input logic [63:0] a, input logic [63:0] b, input logic op);
    req_a[i*64 +: 64] = a;
    req_b[i*64 +: 64] = b;
    req_op[i] = op;
  endtask

  task automatic model_reset();
    exp_q.delete();
    last = N - 1;
    acc_last = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one clock: check outputs against the model just before the edge, then advance the model
  task automatic cyc();
    logic [N-1:0] g;
    bit rv, can;
    int n, gi;
    #1;
    n = exp_q.size();
    rv = (n == 2) || (n == 1 && !acc_last);
    can = !(n == 2 && !resp_ready);
    g = '0;
    gi = -1;
    if (can) for (int k = N; k >= 1; k--) if (req_valid[(last + k) % N]) gi = (last + k) % N;
    if (gi >= 0) g[gi] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(g));
    chk("resp_valid", 64'(resp_valid), 64'(rv));
    chk("busy", 64'(busy), 64'(n > 0));
    if (rv) begin
      chk("resp_id", 64'(resp_id), 64'(exp_q[0].id));
      chk("resp_result", resp_result, exp_q[0].res);
    end
    @(posedge clk);
    if (rv && resp_ready) void'(exp_q.pop_front());
    acc_last = gi >= 0;
    if (gi >= 0) begin
      exp_q.push_back('{gi, ref_add(req_a[gi*64 +: 64], req_b[gi*64 +: 64], req_op[gi])});
      last = gi;
    end
    @(negedge clk);
  endtask

  initial begin
    bit got3;
    int prev, dbl, w;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_result", resp_result, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // single requester
    put(0, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0);
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    cyc();
    chk("t1_valid", 64'(resp_valid), 64'd1);
    chk("t1_id", 64'(resp_id), 64'd0);
    chk("t1_result", resp_result, 64'h4000000000000000);
    cyc();
    cyc();
    // all four requesters continuously valid
    do_reset();
    for (int i = 0; i < N; i++) put(i, 64'h4000000000000000, 64'h4008000000000000, 1'b0);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_grant", 64'(req_ready), 64'(1) << (i % N));
      if (resp_valid) chk("t2_result", resp_result, 64'h4014000000000000);
      cyc();
    end
    req_valid = '0;
    repeat (3) cyc();
    // backpressure with s1 and s2 full
    do_reset();
    put(0, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0);
    put(1, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1);
    req_valid = 4'b0011;
    cyc();
    req_valid = 4'b0010;
    cyc();
    resp_ready = 1'b0;
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_ready_low", 64'(req_ready), 64'd0);
      chk("t3_id_stable", 64'(resp_id), 64'd0);
      chk("t3_result_stable", resp_result, 64'h4008000000000000);
      cyc();
    end
    resp_ready = 1'b1;
    req_valid = '0;
    cyc();
    chk("t3_second_id", 64'(resp_id), 64'd1);
    chk("t3_second_result", resp_result, 64'd0);
    repeat (2) cyc();
    // special values
    put(0, 64'h7FF0000000000000, 64'hFFF0000000000000, 1'b0);
    req_valid = 4'b0001;
    cyc();
    put(0, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0);
    cyc();
    req_valid = '0;
    chk("t4_nan", resp_result, FP_QNAN);
    cyc();
    chk("t4_inf", resp_result, FP_PINF);
    repeat (2) cyc();
    // asynchronous reset with both stages full
    for (int i = 0; i < N; i++) put(i, rand_fp(), rand_fp(), 1'(i));
    req_valid = 4'b0011;
    cyc();
    cyc();
    req_valid = 4'b1100;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_resp_valid", 64'(resp_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_req_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_first_grant", 64'(req_ready), 64'b0100);
    cyc();
    req_valid = '0;
    repeat (3) cyc();
    // fairness: req1 held, req3 raised and held until granted
    put(1, rand_fp(), rand_fp(), 1'b0);
    put(3, rand_fp(), rand_fp(), 1'b1);
    req_valid = 4'b0010;
    cyc();
    req_valid = 4'b1010;
    got3 = 1'b0;
    prev = -1;
    dbl = 0;
    w = 0;
    while (!got3 && w < N) begin
      #1;
      if (req_ready == 4'b1000) got3 = 1'b1;
      if (req_ready == 4'b0010 && prev == 1) dbl++;
      prev = (req_ready == 4'b0010) ? 1 : -1;
      cyc();
      w++;
      if (got3) req_valid[3] = 1'b0;
    end
    chk("t6_req3_granted", 64'(got3), 64'd1);
    chk("t6_no_double_req1", 64'(dbl), 64'd0);
    req_valid = '0;
    repeat (3) cyc();
    // random traffic and backpressure
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) put(i, rand_fp(), rand_fp(), 1'($urandom));
      resp_ready = ($urandom % 4) != 0;
      cyc();
    end
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (4) cyc();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dp_add_arbiter.md
Name: dp_add_arbiter

Overview:
- Shares one combinational dp_adder instance (64-bit a, b, op → result) between NUM_REQ requesters.
- Uses round-robin arbitration, valid/ready request and response handshakes, and a 2-stage registered pipeline (operand stage, result stage).
- Sits between the FPU issue logic / multiple compute clients and the double-precision adder datapath.
- Returns each result tagged with the requester index.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester tag.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operation valid.
- req_ready  output  NUM_REQ  per-requester grant/accept; one-hot or zero.
- req_a  input  NUM_REQ*64  packed operand A; requester i occupies bits [64i+63:64i].
- req_b  input  NUM_REQ*64  packed operand B, same packing.
- req_op  input  NUM_REQ  per-requester op bit, forwarded unchanged to dp_adder op.
- resp_valid  output  1  result stage holds a valid result.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  ID_W  index of the requester that issued the result.
- resp_result  output  64  dp_adder result.
- busy  output  1  high when either pipeline stage is valid.

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, resp_valid=0, resp_id=0, resp_result=0, busy=0, rr pointer=NUM_REQ-1 (requester 0 has highest priority first). req_ready is combinational, so it is 0 while rst is high.
- Stage advance rules:
  - s2_en = !s2_valid | resp_ready.
  - s1_en = !s1_valid | s2_en.
- Grant:
  - When s1_en=1, the arbiter picks the first asserted req_valid searching from pointer+1 upward, modulo NUM_REQ. It drives req_ready one-hot for that index only.
  - When s1_en=0, req_ready=0.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept: req_valid[i] & req_ready[i] at a rising edge.
  - Captures req_a/req_b/req_op slice i and tag i into s1 and sets s1_valid.
  - Updates pointer to i.
  - With no accept, the pointer holds.
- Stage 1 → 2: when s2_en, s2 loads dp_adder(s1_a, s1_b, s1_op), s1_id and s1_valid. dp_adder is fed only from s1 registers, never from req_* directly.
- When s1_en & no grant & s1 advancing, s1_valid clears.
- Latency: accepted in cycle t → resp_valid=1 in cycle t+2 with no backpressure. Throughput is 1 op/cycle.
- Backpressure: while resp_valid & !resp_ready, resp_result and resp_id stay stable.
  - s1 holds if full.
  - req_ready stays 0 until s1 can drain.
  - No result is dropped or duplicated.
- Simultaneous events: the same edge may accept a new request, move s1→s2 and complete a response.
- Arithmetic: no interpretation of the IEEE-754 fields. NaN, Inf, subnormal, rounding and overflow behaviour are entirely dp_adder's.
- busy = s1_valid | s2_valid.
- Reset mid-operation: in-flight operations are discarded without response and the pointer returns to NUM_REQ-1. After release, the first grant goes to the lowest valid index.

Decomposition:
- Package dp_fpu_pkg holds:
  - FP_W=64.
  - FP_QNAN=64'h7FF8000000000000.
  - FP_PINF=64'h7FF0000000000000.
  - A function returning the requester tag width.
- One natural sub-module: rr_arbiter (NUM_REQ request vector, enable, pointer update on accept, one-hot grant plus encoded index).
- dp_adder is instantiated unchanged.

Test Plan:
1. Single requester: req0 a=3FF0000000000000, b=3FF0000000000000, op=0, resp_ready=1 → resp_valid two cycles after accept, resp_id=0, resp_result=4000000000000000, busy high for 2 cycles.
2. All four requesters valid continuously, each with a=4000000000000000, b=4008000000000000 → grants strictly in order 0,1,2,3,0, one per cycle. Every response is 4014000000000000 with resp_id matching grant order.
3. Backpressure: two back-to-back accepts, then resp_ready=0 for 3 cycles → resp_result/resp_id stable, req_ready=0 while s1 full. After resp_ready=1, both results emerge in order with none lost.
4. Special values through the pipeline: a=7FF0000000000000, b=FFF0000000000000 → resp_result=7FF8000000000000. Then a=7FEFFFFFFFFFFFFF, b=7FEFFFFFFFFFFFFF → 7FF0000000000000.
5. Reset mid-operation: assert rst asynchronously with s1 and s2 both valid → resp_valid, busy and req_ready drop immediately. After release with req2 and req3 valid, the first grant is 2 and no stale response appears.
6. Pointer fairness: req1 continuously valid, req3 pulsed → req3 is granted within NUM_REQ cycles and req1 is never granted twice in a row while req3 waits.
